// File: rtl/ysyx_22050243_arb_pkg.sv
// Shared types and limits for the round-robin arbiter/mux.
// No logic; latency and backpressure are properties of the users.
// Provides the lock-state encoding, the channel upper bound and the id width helper.
package ysyx_22050243_arb_pkg;

  // Largest channel count the arbiter is built and checked for
  localparam int unsigned ARB_MAX_CH = 16;

  // Burst lock state: IDLE re-arbitrates every beat, LOCK pins the grant to the owner
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Channel index width, never narrower than one bit
  function automatic int unsigned arb_id_len(input int unsigned nr_ch);
    return (nr_ch <= 1) ? 1 : $clog2(nr_ch);
  endfunction

endpackage

// File: rtl/ysyx_22050243_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NR_CH.
// Purely combinational, zero latency.
// No backpressure of its own; the caller decides whether the grant is used.
module ysyx_22050243_rr_pick
  import ysyx_22050243_arb_pkg::*;
#(
  parameter  int unsigned NR_CH  = 4,
  localparam int unsigned ID_LEN = arb_id_len(NR_CH)
) (
  input  logic [NR_CH-1:0]  req_i,
  input  logic [ID_LEN-1:0] ptr_i,
  output logic [NR_CH-1:0]  grant_o,
  output logic [ID_LEN-1:0] idx_o,
  output logic              vld_o
);

  localparam int NCH = NR_CH;

  logic [2*NR_CH-1:0] req_dbl;
  logic [2*NR_CH-1:0] req_msk;
  int                 hit;

  // Two copies of the request vector; bits below ptr in the lower copy are masked so the
  // lowest surviving bit is the next requester in round-robin order, wrapping naturally
  always_comb begin
    req_dbl = {req_i, req_i};
    req_msk = '0;
    for (int i = 0; i < 2 * NCH; i++) begin
      req_msk[i] = req_dbl[i] && (i >= int'(ptr_i));
    end
  end

  // Lowest set bit of the masked vector, folded back into channel range
  always_comb begin
    hit   = 0;
    vld_o = 1'b0;
    for (int i = 2 * NCH - 1; i >= 0; i--) begin
      if (req_msk[i]) begin
        hit   = (i >= NCH) ? i - NCH : i;
        vld_o = 1'b1;
      end
    end
    idx_o = ID_LEN'(hit);
    for (int c = 0; c < NCH; c++) begin
      grant_o[c] = vld_o && (c == hit);
    end
  end

endmodule

// File: rtl/ysyx_22050243_arb_mux.sv
// N-channel round-robin arbiter and data mux feeding one registered output slice.
// Latency 1 cycle; one beat per cycle while out_ready is high (slot refills as it drains).
// Backpressure: out_valid && !out_ready holds out_* stable and clears every in_ready bit.
// Burst locking (grant pinned to one channel until its in_last beat) is built only when
// the macro ARB_MUX_LOCK_EN is defined; otherwise every beat re-arbitrates.
module ysyx_22050243_arb_mux
  import ysyx_22050243_arb_pkg::*;
#(
  parameter  int unsigned NR_CH    = 4,
  parameter  int unsigned DATA_LEN = 64,
  localparam int unsigned ID_LEN   = arb_id_len(NR_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR_CH-1:0]          in_valid,
  output logic [NR_CH-1:0]          in_ready,
  input  logic [NR_CH*DATA_LEN-1:0] in_data,
  input  logic [NR_CH-1:0]          in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_LEN-1:0]       out_data,
  output logic [ID_LEN-1:0]         out_id,
  output logic                      out_last
);

  if (NR_CH < 1 || NR_CH > ARB_MAX_CH) begin : g_bad_nr_ch
    $error("NR_CH must be between 1 and ARB_MAX_CH");
  end

  localparam int NCH = NR_CH;

  logic                slot_free;
  logic [NR_CH-1:0]    rr_grant;
  logic [ID_LEN-1:0]   rr_idx;
  logic                rr_vld;
  logic                win_vld;
  logic [ID_LEN-1:0]   win_idx;
  logic [NR_CH-1:0]    win_oh;
  logic                acc;
  logic                ptr_adv;
  logic [ID_LEN-1:0]   ptr_q, ptr_d, ptr_inc;
  logic [DATA_LEN-1:0] sel_data;
  logic                sel_last;

  logic                out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0] out_data_q,  out_data_d;
  logic [ID_LEN-1:0]   out_id_q,    out_id_d;
  logic                out_last_q,  out_last_d;

  assign slot_free = !out_valid_q || out_ready;

  ysyx_22050243_rr_pick #(
    .NR_CH (NR_CH)
  ) u_pick (
    .req_i   (in_valid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .vld_o   (rr_vld)
  );

`ifdef ARB_MUX_LOCK_EN
  arb_state_e        state_q;
  logic [ID_LEN-1:0] own_q;
  logic [NR_CH-1:0]  own_oh;
  logic              locked;

  // One-hot view of the lock owner for the grant/data path
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      own_oh[c] = (ID_LEN'(c) == own_q);
    end
  end

  assign locked  = (state_q == ARB_LOCK);
  // While locked the owner holds the grant even with in_valid low, so gaps in a burst
  // never let another channel slip in
  assign win_vld = locked || rr_vld;
  assign win_idx = locked ? own_q  : rr_idx;
  assign win_oh  = locked ? own_oh : rr_grant;
  // The pointer only moves once a burst finishes
  assign ptr_adv = sel_last;

  // Lock FSM: a non-last beat from IDLE captures the owner, the owner's last beat releases it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      own_q   <= '0;
    end else if (acc) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (!sel_last) begin
            state_q <= ARB_LOCK;
            own_q   <= win_idx;
          end
        end
        ARB_LOCK: begin
          if (sel_last) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end
`else
  // Every beat re-arbitrates; in_last only rides along to out_last
  assign win_vld = rr_vld;
  assign win_idx = rr_idx;
  assign win_oh  = rr_grant;
  assign ptr_adv = 1'b1;
`endif

  assign in_ready = (win_vld && slot_free && !rst) ? win_oh : '0;
  assign acc      = |(in_valid & in_ready);

  // AND-OR select of the granted channel's payload; no arithmetic on the data path
  always_comb begin
    sel_data = '0;
    for (int c = 0; c < NCH; c++) begin
      sel_data = sel_data | (in_data[c*DATA_LEN +: DATA_LEN] & {DATA_LEN{win_oh[c]}});
    end
  end

  assign sel_last = |(in_last & win_oh);

  // Pointer steps to the channel after the winner, wrapping at NR_CH (held at 0 for one channel)
  always_comb begin
    ptr_inc = (int'(win_idx) >= NCH - 1) ? '0 : win_idx + ID_LEN'(1);
    ptr_d   = ptr_q;
    if (acc && ptr_adv) begin
      ptr_d = ptr_inc;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Output slice next state: load on accept, empty when drained without a refill
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_id_d    = win_idx;
      out_last_d  = sel_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slice register; reset discards any pending beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;

endmodule
